// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle for muldiv_seq.
// master = issuing pipeline, slave = the multiply/divide unit.
interface muldiv_seq_if #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_SIZE = 5
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [2:0]                funct3_i;
  logic [WD_SIZE-1:0]        op1_i;
  logic [WD_SIZE-1:0]        op2_i;
  logic [INSTR_REG_SIZE-1:0] rd_i;
  logic                      flush_i;
  logic                      resp_valid_o;
  logic                      resp_ready_i;
  logic [WD_SIZE-1:0]        resp_data_o;
  logic [INSTR_REG_SIZE-1:0] resp_rd_o;
  logic                      busy_o;

  modport master (
    output req_valid_i, funct3_i, op1_i, op2_i, rd_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, busy_o
  );

  modport slave (
    input  req_valid_i, funct3_i, op1_i, op2_i, rd_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, busy_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply (single cycle) / restoring divide (one bit per cycle).
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow directly from IDLE.
module muldiv_seq #(
   parameter int unsigned WD_SIZE        = 32,
   parameter int unsigned DIV_ITERS      = WD_SIZE,
   parameter int unsigned INSTR_REG_SIZE = 5
) (
   input logic        clk,
   input logic        reset,
   muldiv_seq_if.slave io
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   localparam int unsigned CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);
   localparam logic [WD_SIZE-1:0] MOST_NEG = {1'b1, {(WD_SIZE-1){1'b0}}};

   state_t                    state_q, state_d;
   logic [WD_SIZE-1:0]        op1_q, op2_q, quot_q, rem_q, dvsr_q, result_q;
   logic [2:0]                f3_q;
   logic [INSTR_REG_SIZE-1:0] rd_q;
   logic [CW-1:0]             cnt_q;
   logic                      accept, early_out;
   logic                      mul_s1, mul_s2;
   logic [2*WD_SIZE-1:0]      mul_a, mul_b, prod;
   logic [WD_SIZE:0]          shifted;
   logic                      sub_ok;
   logic [WD_SIZE-1:0]        abs1, abs2;

   // Final divide result from magnitudes, with the zero-divisor and overflow overrides.
   function automatic logic [WD_SIZE-1:0] div_result(input logic [2:0] f3,
                                                      input logic [WD_SIZE-1:0] a, b, q, r);
      logic sgn, na, nb, ovf;
      sgn = ~f3[0];
      na  = sgn & a[WD_SIZE-1];
      nb  = sgn & b[WD_SIZE-1];
      ovf = sgn && (a == MOST_NEG) && (b == '1);
      if (!f3[1]) begin
         if (b == '0) return '1;
         if (ovf)     return a;
         return (na ^ nb) ? -q : q;
      end
      if (b == '0) return a;
      if (ovf)     return '0;
      return na ? -r : r;
   endfunction

   assign io.req_ready_o = (state_q == IDLE) & ~io.flush_i & ~reset;
   assign io.busy_o      = (state_q != IDLE);
   assign accept         = io.req_valid_i & io.req_ready_o;

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = io.funct3_i[2] &
                      ((io.op2_i == '0) ||
                       (~io.funct3_i[0] && (io.op1_i == MOST_NEG) && (io.op2_i == '1)));
`else
   assign early_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (io.flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (accept) state_d = !io.funct3_i[2] ? MUL : (early_out ? DONE : DIV);
            MUL:  state_d = DONE;
            DIV:  if (cnt_q == LAST_ITER) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (io.resp_valid_o && io.resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Sign-extend to 2*WD_SIZE so one unsigned multiply covers all three signedness mixes.
   always_comb begin
      mul_s1 = ~(f3_q[1] & f3_q[0]);
      mul_s2 = ~f3_q[1] & f3_q[0];
      mul_a  = {{WD_SIZE{mul_s1 & op1_q[WD_SIZE-1]}}, op1_q};
      mul_b  = {{WD_SIZE{mul_s2 & op2_q[WD_SIZE-1]}}, op2_q};
      prod   = mul_a * mul_b;
   end

   always_comb begin
      shifted = {rem_q, quot_q[WD_SIZE-1]};
      sub_ok  = (shifted >= {1'b0, dvsr_q});
      abs1    = (~io.funct3_i[0] & io.op1_i[WD_SIZE-1]) ? -io.op1_i : io.op1_i;
      abs2    = (~io.funct3_i[0] & io.op2_i[WD_SIZE-1]) ? -io.op2_i : io.op2_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op1_q           <= '0;
         op2_q           <= '0;
         quot_q          <= '0;
         rem_q           <= '0;
         dvsr_q          <= '0;
         result_q        <= '0;
         f3_q            <= '0;
         rd_q            <= '0;
         cnt_q           <= '0;
         io.resp_valid_o <= 1'b0;
         io.resp_data_o  <= '0;
         io.resp_rd_o    <= '0;
      end else begin
         // Output register stage: the first DONE cycle loads data, valid follows one edge later.
         io.resp_valid_o <= (state_q == DONE) && (state_d == DONE);
         if (accept) begin
            op1_q    <= io.op1_i;
            op2_q    <= io.op2_i;
            f3_q     <= io.funct3_i;
            rd_q     <= io.rd_i;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= abs1;
            dvsr_q   <= abs2;
            result_q <= div_result(io.funct3_i, io.op1_i, io.op2_i, '0, '0);
         end
         if (state_q == MUL) begin
            result_q <= (f3_q == 3'b000) ? prod[WD_SIZE-1:0] : prod[2*WD_SIZE-1:WD_SIZE];
         end
         if (state_q == DIV) begin
            rem_q  <= sub_ok ? (shifted[WD_SIZE-1:0] - dvsr_q) : shifted[WD_SIZE-1:0];
            quot_q <= {quot_q[WD_SIZE-2:0], sub_ok};
            cnt_q  <= cnt_q + CW'(1);
         end
         if (state_q == FIX) begin
            result_q <= div_result(f3_q, op1_q, op2_q, quot_q, rem_q);
         end
         if (state_q == DONE && !io.resp_valid_o) begin
            io.resp_data_o <= result_q;
            io.resp_rd_o   <= rd_q;
         end
      end
   end

endmodule
